// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic [DATA_W-1:0] src1_0_i,
    input  logic [DATA_W-1:0] src2_0_i,
    input  logic [DATA_W-1:0] src1_1_i,
    input  logic [DATA_W-1:0] src2_1_i,
    input  logic [4:0]        shmat0_i,
    input  logic [4:0]        shmat1_i,
    input  logic [3:0]        ctrl0_i,
    input  logic [3:0]        ctrl1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [4:0]        alu_shmat_o,
    output logic [3:0]        alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    output logic              rsp_valid_o,
    output logic              rsp_id_o,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_zero_o,
    input  logic              rsp_ready_i,
    output logic              busy_o
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_RESP = 2'b10;

    logic [1:0]        r_state;
    logic              r_owner;
    logic [DATA_W-1:0] r_alu_src1;
    logic [DATA_W-1:0] r_alu_src2;
    logic [4:0]        r_alu_shmat;
    logic [3:0]        r_alu_ctrl;
    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_zero;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic              r_last_gnt;
`endif

    logic w_can_acc;
    logic w_accept;
    logic w_win1;

    always_comb begin
        w_can_acc = (r_state == S_IDLE) ||
                    ((r_state == S_RESP) && rsp_ready_i);
        w_accept  = !rst_i && w_can_acc && (req0_i || req1_i);
`ifdef ALU_ARB_FIXED_PRIO_EN
        w_win1    = req1_i && !req0_i;
`else
        // On a tie the requester that did not win last time goes first.
        w_win1    = req1_i && (!req0_i || !r_last_gnt);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_alu_src1   <= '0;
            r_alu_src2   <= '0;
            r_alu_shmat  <= '0;
            r_alu_ctrl   <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last_gnt   <= 1'b1;
`endif
        end else if (w_accept) begin
            r_state     <= S_EXEC;
            r_owner     <= w_win1;
            r_alu_src1  <= w_win1 ? src1_1_i : src1_0_i;
            r_alu_src2  <= w_win1 ? src2_1_i : src2_0_i;
            r_alu_shmat <= w_win1 ? shmat1_i : shmat0_i;
            r_alu_ctrl  <= w_win1 ? ctrl1_i  : ctrl0_i;
            r_rsp_valid <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last_gnt  <= w_win1;
`endif
        end else begin
            case (r_state)
                S_EXEC: begin
                    r_state      <= S_RESP;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_id     <= r_owner;
                    r_rsp_result <= alu_result_i;
                    r_rsp_zero   <= alu_zero_i;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0_o       = w_accept && !w_win1;
    assign gnt1_o       = w_accept && w_win1;
    assign alu_src1_o   = r_alu_src1;
    assign alu_src2_o   = r_alu_src2;
    assign alu_shmat_o  = r_alu_shmat;
    assign alu_ctrl_o   = r_alu_ctrl;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_id_o     = r_rsp_id;
    assign rsp_result_o = r_rsp_result;
    assign rsp_zero_o   = r_rsp_zero;
    assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the shared ALU.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_i;
    logic        req0_i, req1_i;
    logic [31:0] src1_0_i, src2_0_i, src1_1_i, src2_1_i;
    logic [4:0]  shmat0_i, shmat1_i;
    logic [3:0]  ctrl0_i, ctrl1_i;
    logic        gnt0_o, gnt1_o;
    logic [31:0] alu_src1_o, alu_src2_o;
    logic [4:0]  alu_shmat_o;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_result_i;
    logic        alu_zero_i;
    logic        rsp_valid_o, rsp_id_o, rsp_zero_o;
    logic [31:0] rsp_result_o;
    logic        rsp_ready_i;
    logic        busy_o;

    int n_ok = 0;
    int n_tot = 0;

    alu_arbiter #(.DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_i(req0_i), .req1_i(req1_i),
        .src1_0_i(src1_0_i), .src2_0_i(src2_0_i),
        .src1_1_i(src1_1_i), .src2_1_i(src2_1_i),
        .shmat0_i(shmat0_i), .shmat1_i(shmat1_i),
        .ctrl0_i(ctrl0_i), .ctrl1_i(ctrl1_i),
        .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
        .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
        .alu_shmat_o(alu_shmat_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
        .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o),
        .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o),
        .rsp_ready_i(rsp_ready_i), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the shared ALU.
    function automatic logic [31:0] ref_alu(input logic [3:0] c,
                                            input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [4:0] sh);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return {31'b0, $signed(a) < $signed(b)};
            4'b1000: return a << sh;
            4'b1001: return a >> sh;
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        alu_result_i = ref_alu(alu_ctrl_o, alu_src1_o, alu_src2_o, alu_shmat_o);
        alu_zero_i   = (alu_result_i == 32'h0);
    end

    logic [3:0]  codes [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                               4'b0111, 4'b1000, 4'b1001, 4'b1111};
    logic [3:0]  tc_c  [5] = '{4'b0111, 4'b0111, 4'b0000, 4'b1111, 4'b0001};
    logic [31:0] tc_a  [5] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_0000,
                               32'h1234_5678, 32'h0000_00F0};
    logic [31:0] tc_b  [5] = '{32'd3, 32'd1, 32'h0000_FFFF,
                               32'd1, 32'h0000_000F};
    logic [4:0]  tc_s  [5] = '{5'd0, 5'd3, 5'd9, 5'd31, 5'd17};
    logic [31:0] tc_r  [5] = '{32'd0, 32'd1, 32'd0, 32'd0, 32'hFF};
    logic        tc_z  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    task automatic next_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic r, input logic [3:0] c,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] s);
        req0_i = r; ctrl0_i = c; src1_0_i = a; src2_0_i = b; shmat0_i = s;
    endtask

    task automatic drive1(input logic r, input logic [3:0] c,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] s);
        req1_i = r; ctrl1_i = c; src1_1_i = a; src2_1_i = b; shmat1_i = s;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        rsp_ready_i = 1'b1;
        drive0(1'b0, 4'h0, 32'h0, 32'h0, 5'h0);
        drive1(1'b0, 4'h0, 32'h0, 32'h0, 5'h0);
        next_slot();
        next_slot();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        rsp_ready_i = 1'b1;
        drive0(1'b1, 4'h2, 32'd1, 32'd2, 5'd3);
        drive1(1'b1, 4'h1, 32'd4, 32'd5, 5'd6);
        @(negedge clk);
        n_tot++;
        if ({gnt0_o, gnt1_o} !== 2'b00)
            $display("FAIL reset_gnt got %b exp 00", {gnt0_o, gnt1_o});
        else n_ok++;
        n_tot++;
        if ({alu_src1_o, alu_src2_o, alu_shmat_o, alu_ctrl_o} !== 73'h0)
            $display("FAIL reset_alu got %h/%h/%h/%h exp 0", alu_src1_o,
                     alu_src2_o, alu_shmat_o, alu_ctrl_o);
        else n_ok++;
        n_tot++;
        if ({rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, busy_o} !== 36'h0)
            $display("FAIL reset_rsp got v%b id%b r%h z%b b%b exp 0", rsp_valid_o,
                     rsp_id_o, rsp_result_o, rsp_zero_o, busy_o);
        else n_ok++;
        next_slot();
    endtask

    task automatic test_add();
        do_reset();
        drive0(1'b1, 4'b0010, 32'd5, 32'd7, 5'd0);
        @(negedge clk);
        n_tot++;
        if ({gnt0_o, gnt1_o} !== 2'b10)
            $display("FAIL add_gnt got %b exp 10", {gnt0_o, gnt1_o});
        else n_ok++;
        next_slot();
        drive0(1'b0, 4'h0, 32'h0, 32'h0, 5'h0);
        @(negedge clk);
        n_tot++;
        if ({busy_o, rsp_valid_o, gnt0_o} !== 3'b100)
            $display("FAIL add_exec got b%b v%b g%b exp b1 v0 g0",
                     busy_o, rsp_valid_o, gnt0_o);
        else n_ok++;
        n_tot++;
        if ({alu_ctrl_o, alu_src1_o, alu_src2_o} !== {4'b0010, 32'd5, 32'd7})
            $display("FAIL add_alu got %h %h %h exp 2 5 7",
                     alu_ctrl_o, alu_src1_o, alu_src2_o);
        else n_ok++;
        next_slot();
        @(negedge clk);
        n_tot++;
        if ({rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o} !== {2'b10, 32'd12, 1'b0})
            $display("FAIL add_rsp got v%b id%b r%0d z%b exp v1 id0 r12 z0",
                     rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o);
        else n_ok++;
        next_slot();
        @(negedge clk);
        n_tot++;
        if ({rsp_valid_o, busy_o} !== 2'b00)
            $display("FAIL add_done got v%b b%b exp 00", rsp_valid_o, busy_o);
        else n_ok++;
        next_slot();
    endtask

    task automatic test_round_robin();
        logic       exp_id;
        logic [1:0] exp_g;
        do_reset();
        drive0(1'b1, 4'b0110, 32'd9, 32'd9, 5'd0);
        drive1(1'b1, 4'b0001, 32'hF0, 32'h0F, 5'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b00;
`else
            exp_g = (k % 2 != 0) ? 2'b00 : ((k / 2) % 2 == 0 ? 2'b10 : 2'b01);
`endif
            n_tot++;
            if ({gnt0_o, gnt1_o} !== exp_g)
                $display("FAIL rr_gnt slot %0d got %b exp %b", k,
                         {gnt0_o, gnt1_o}, exp_g);
            else n_ok++;
            if (k >= 2 && k % 2 == 0) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                exp_id = 1'b0;
`else
                exp_id = ((k - 2) / 2) % 2 == 1;
`endif
                n_tot++;
                if ({rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o} !==
                    {1'b1, exp_id, exp_id ? 32'hFF : 32'h0, !exp_id})
                    $display("FAIL rr_rsp slot %0d got v%b id%b r%h z%b exp id%b",
                             k, rsp_valid_o, rsp_id_o, rsp_result_o,
                             rsp_zero_o, exp_id);
                else n_ok++;
            end
            next_slot();
        end
    endtask

    task automatic test_stall();
        do_reset();
        rsp_ready_i = 1'b0;
        drive0(1'b1, 4'b0010, 32'd1, 32'd2, 5'd0);
        @(negedge clk);
        n_tot++;
        if ({gnt0_o, gnt1_o} !== 2'b10)
            $display("FAIL stall_gnt0 got %b exp 10", {gnt0_o, gnt1_o});
        else n_ok++;
        next_slot();
        drive0(1'b0, 4'h0, 32'h0, 32'h0, 5'h0);
        drive1(1'b1, 4'b0010, 32'd3, 32'd4, 5'd0);
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            n_tot++;
            if ({gnt0_o, gnt1_o} !== 2'b00)
                $display("FAIL stall_nogrant slot %0d got %b exp 00", k,
                         {gnt0_o, gnt1_o});
            else n_ok++;
            if (k >= 2) begin
                n_tot++;
                if ({rsp_valid_o, rsp_id_o, rsp_result_o} !== {2'b10, 32'd3})
                    $display("FAIL stall_hold slot %0d got v%b id%b r%0d exp v1 id0 r3",
                             k, rsp_valid_o, rsp_id_o, rsp_result_o);
                else n_ok++;
            end
            next_slot();
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        n_tot++;
        if ({gnt0_o, gnt1_o, rsp_valid_o, rsp_result_o} !== {3'b011, 32'd3})
            $display("FAIL stall_release got g%b v%b r%0d exp g01 v1 r3",
                     {gnt0_o, gnt1_o}, rsp_valid_o, rsp_result_o);
        else n_ok++;
        next_slot();
        drive1(1'b0, 4'h0, 32'h0, 32'h0, 5'h0);
        next_slot();
        @(negedge clk);
        n_tot++;
        if ({rsp_valid_o, rsp_id_o, rsp_result_o} !== {2'b11, 32'd7})
            $display("FAIL stall_rsp1 got v%b id%b r%0d exp v1 id1 r7",
                     rsp_valid_o, rsp_id_o, rsp_result_o);
        else n_ok++;
        next_slot();
    endtask

    task automatic test_codes();
        do_reset();
        for (int t = 0; t < 5; t++) begin
            drive0(1'b1, tc_c[t], tc_a[t], tc_b[t], tc_s[t]);
            @(negedge clk);
            n_tot++;
            if (gnt0_o !== 1'b1)
                $display("FAIL codes_gnt op %0d got %b exp 1", t, gnt0_o);
            else n_ok++;
            next_slot();
            drive0(1'b0, 4'h0, 32'h0, 32'h0, 5'h0);
            @(negedge clk);
            n_tot++;
            if ({alu_ctrl_o, alu_shmat_o} !== {tc_c[t], tc_s[t]})
                $display("FAIL codes_alu op %0d got c%h s%0d exp c%h s%0d", t,
                         alu_ctrl_o, alu_shmat_o, tc_c[t], tc_s[t]);
            else n_ok++;
            next_slot();
            @(negedge clk);
            n_tot++;
            if ({rsp_valid_o, rsp_result_o, rsp_zero_o} !== {1'b1, tc_r[t], tc_z[t]})
                $display("FAIL codes_rsp op %0d got v%b r%h z%b exp r%h z%b", t,
                         rsp_valid_o, rsp_result_o, rsp_zero_o, tc_r[t], tc_z[t]);
            else n_ok++;
            next_slot();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive0(1'b1, 4'b0010, 32'd2, 32'd2, 5'd0);
        next_slot();
        drive0(1'b0, 4'h0, 32'h0, 32'h0, 5'h0);
        rst_i = 1'b1;
        @(negedge clk);
        n_tot++;
        if ({busy_o, gnt0_o, gnt1_o} !== 3'b100)
            $display("FAIL rstmid_exec got b%b g%b exp b1 g00", busy_o,
                     {gnt0_o, gnt1_o});
        else n_ok++;
        next_slot();
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tot++;
            if ({rsp_valid_o, busy_o} !== 2'b00)
                $display("FAIL rstmid_idle slot %0d got v%b b%b exp 00", k,
                         rsp_valid_o, busy_o);
            else n_ok++;
            next_slot();
        end
    endtask

    task automatic test_drop();
        do_reset();
        drive0(1'b1, 4'b0010, 32'd10, 32'd20, 5'd0);
        @(negedge clk);
        n_tot++;
        if ({gnt0_o, gnt1_o} !== 2'b10)
            $display("FAIL drop_gnt0 got %b exp 10", {gnt0_o, gnt1_o});
        else n_ok++;
        next_slot();
        drive0(1'b0, 4'h0, 32'h0, 32'h0, 5'h0);
        drive1(1'b1, 4'b0001, 32'd1, 32'd2, 5'd0);
        @(negedge clk);
        n_tot++;
        if ({gnt0_o, gnt1_o} !== 2'b00)
            $display("FAIL drop_exec got %b exp 00", {gnt0_o, gnt1_o});
        else n_ok++;
        next_slot();
        @(negedge clk);
        n_tot++;
        if ({gnt0_o, gnt1_o, rsp_id_o, rsp_result_o} !== {3'b010, 32'd30})
            $display("FAIL drop_gnt1 got g%b id%b r%0d exp g01 id0 r30",
                     {gnt0_o, gnt1_o}, rsp_id_o, rsp_result_o);
        else n_ok++;
        next_slot();
        drive1(1'b0, 4'h0, 32'h0, 32'h0, 5'h0);
        next_slot();
        @(negedge clk);
        n_tot++;
        if ({gnt0_o, gnt1_o, rsp_valid_o, rsp_id_o, rsp_result_o} !== {4'b0011, 32'd3})
            $display("FAIL drop_rsp1 got g%b v%b id%b r%0d exp g00 v1 id1 r3",
                     {gnt0_o, gnt1_o}, rsp_valid_o, rsp_id_o, rsp_result_o);
        else n_ok++;
        next_slot();
    endtask

    // Model: an op occupies the ALU from its accept cycle; its answer is
    // offered two cycles later and held until taken.
    task automatic test_random();
        logic        pend [2];
        logic [3:0]  op_c [2];
        logic [31:0] op_a [2];
        logic [31:0] op_b [2];
        logic [4:0]  op_s [2];
        logic        m_busy, m_id, m_prefer, m_zero;
        logic [31:0] m_res;
        logic [72:0] m_alu;
        int          m_acc;
        logic        can, w, exp_acc, exp_v;
        logic [1:0]  exp_g;
        do_reset();
        pend = '{1'b0, 1'b0};
        m_busy = 1'b0; m_prefer = 1'b0; m_acc = 0; m_id = 1'b0;
        m_res = '0; m_zero = 1'b0; m_alu = '0;
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1'b1;
                    op_c[r] = codes[$urandom_range(0, 7)];
                    op_a[r] = $urandom;
                    op_b[r] = ($urandom_range(0, 3) == 0) ? op_a[r] : $urandom;
                    op_s[r] = 5'($urandom_range(0, 31));
                end
            end
            drive0(pend[0], op_c[0], op_a[0], op_b[0], op_s[0]);
            drive1(pend[1], op_c[1], op_a[1], op_b[1], op_s[1]);
            rsp_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_v   = m_busy && (i >= m_acc + 2);
            can     = !m_busy || (exp_v && rsp_ready_i);
            w       = (pend[0] && pend[1]) ? m_prefer : pend[1];
            exp_acc = can && (pend[0] || pend[1]);
            exp_g   = exp_acc ? (w ? 2'b01 : 2'b10) : 2'b00;
            n_tot++;
            if ({gnt0_o, gnt1_o} !== exp_g)
                $display("FAIL rnd_gnt cyc %0d got %b exp %b", i,
                         {gnt0_o, gnt1_o}, exp_g);
            else n_ok++;
            n_tot++;
            if ({busy_o, rsp_valid_o} !== {m_busy, exp_v})
                $display("FAIL rnd_state cyc %0d got b%b v%b exp b%b v%b", i,
                         busy_o, rsp_valid_o, m_busy, exp_v);
            else n_ok++;
            if (exp_v) begin
                n_tot++;
                if ({rsp_id_o, rsp_result_o, rsp_zero_o} !== {m_id, m_res, m_zero})
                    $display("FAIL rnd_rsp cyc %0d got id%b r%h z%b exp id%b r%h z%b",
                             i, rsp_id_o, rsp_result_o, rsp_zero_o,
                             m_id, m_res, m_zero);
                else n_ok++;
            end
            if (m_busy && i == m_acc + 1) begin
                n_tot++;
                if ({alu_ctrl_o, alu_src1_o, alu_src2_o, alu_shmat_o} !== m_alu)
                    $display("FAIL rnd_alu cyc %0d got %h exp %h", i,
                             {alu_ctrl_o, alu_src1_o, alu_src2_o, alu_shmat_o}, m_alu);
                else n_ok++;
            end
            if (exp_acc) begin
                m_busy = 1'b1;
                m_acc  = i;
                m_id   = w;
                m_res  = ref_alu(op_c[w], op_a[w], op_b[w], op_s[w]);
                m_zero = (m_res == 32'h0);
                m_alu  = {op_c[w], op_a[w], op_b[w], op_s[w]};
                pend[w] = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                m_prefer = !w;
`endif
            end else if (exp_v && rsp_ready_i) begin
                m_busy = 1'b0;
            end
            next_slot();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_round_robin();
        test_stall();
        test_codes();
        test_reset_mid();
        test_drop();
        test_random();
        $display("%0d/%0d checks passed", n_ok, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
